// File: rtl/flap_motion_if.sv
// Game-side bundle for the flap controller: raw key and enable in,
// motion direction, speed profile and pulses out.
interface flap_motion_if #(
  parameter int VEL_W = 4
);
  logic             key_press;
  logic             enable;
  logic             up;
  logic             down;
  logic [VEL_W-1:0] speed;
  logic             move_tick;
  logic             flap_pulse;

  // Drives the key and enable, observes the motion outputs.
  modport master (
    output key_press, enable,
    input  up, down, speed, move_tick, flap_pulse
  );

  // The controller itself.
  modport slave (
    input  key_press, enable,
    output up, down, speed, move_tick, flap_pulse
  );
endinterface

// File: rtl/flap_motion_ctrl.sv
// Flap/gravity controller for the flappy-dot game.
// Turns each press of the active-low key into one flap, holds an upward
// flight window of FLY_TICKS cycles, then falls with a saturating speed.
// All outputs are registered.
module flap_motion_ctrl #(
  parameter int FLY_TICKS = 35000000,
  parameter int TIMER_W   = 28,
  parameter int TICK_DIV  = 500000,
  parameter int VEL_W     = 4,
  parameter int MAX_RISE  = 7,
  parameter int MAX_FALL  = 7
) (
  input  logic         clk50,
  input  logic         reset,
  flap_motion_if.slave bus
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TIMER_W-1:0] FLY_LOAD  = TIMER_W'(FLY_TICKS - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0]  TICK_ONE  = TICK_W'(1);
  localparam logic [VEL_W-1:0]   RISE_LOAD = VEL_W'(MAX_RISE);
  localparam logic [VEL_W-1:0]   FALL_MAX  = VEL_W'(MAX_FALL);
  localparam logic [VEL_W-1:0]   SPEED_ONE = VEL_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RISE,
    ST_FALL
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;

  logic               r_syncS1;
  logic               r_syncS2;
  logic               r_syncS3;
  logic               w_press;

  logic [TIMER_W-1:0] r_flyTimer;
  logic [TIMER_W-1:0] w_flyTimerNext;
  logic [TICK_W-1:0]  r_tickCnt;
  logic [TICK_W-1:0]  w_tickCntNext;
  logic [TICK_W-1:0]  w_tickAdvance;
  logic               w_tickWrap;
  logic [VEL_W-1:0]   r_speed;
  logic [VEL_W-1:0]   w_speedNext;

  logic               r_up;
  logic               r_down;
  logic               r_moveTick;
  logic               w_moveTickNext;
  logic               r_flapPulse;
  logic               w_flapPulseNext;

  // Key synchroniser plus edge flop; reset high so an idle (released) key gives no edge.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_syncS1 <= 1'b1;
      r_syncS2 <= 1'b1;
      r_syncS3 <= 1'b1;
    end else begin
      r_syncS1 <= bus.key_press;
      r_syncS2 <= r_syncS1;
      r_syncS3 <= r_syncS2;
    end
  end

  assign w_press       = r_syncS3 & ~r_syncS2;
  assign w_tickWrap    = (r_tickCnt == TICK_LAST);
  assign w_tickAdvance = w_tickWrap ? '0 : (r_tickCnt + TICK_ONE);

  // State register with counters and registered outputs taken from the next-state logic.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_flyTimer  <= '0;
      r_tickCnt   <= '0;
      r_speed     <= '0;
      r_up        <= 1'b0;
      r_down      <= 1'b0;
      r_moveTick  <= 1'b0;
      r_flapPulse <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_flyTimer  <= w_flyTimerNext;
      r_tickCnt   <= w_tickCntNext;
      r_speed     <= w_speedNext;
      r_up        <= (w_stateNext == ST_RISE);
      r_down      <= (w_stateNext == ST_FALL);
      r_moveTick  <= w_moveTickNext;
      r_flapPulse <= w_flapPulseNext;
    end
  end

  // Next state: disable beats everything, then a flap beats timer expiry and tick updates.
  always_comb begin
    w_stateNext     = r_state;
    w_flyTimerNext  = r_flyTimer;
    w_tickCntNext   = r_tickCnt;
    w_speedNext     = r_speed;
    w_moveTickNext  = 1'b0;
    w_flapPulseNext = 1'b0;

    if (!bus.enable) begin
      w_stateNext    = ST_IDLE;
      w_flyTimerNext = '0;
      w_tickCntNext  = '0;
      w_speedNext    = '0;
    end else if (w_press) begin
      w_stateNext     = ST_RISE;
      w_flyTimerNext  = FLY_LOAD;
      w_tickCntNext   = '0;
      w_speedNext     = RISE_LOAD;
      w_flapPulseNext = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_stateNext    = ST_FALL;
          w_flyTimerNext = '0;
          w_tickCntNext  = '0;
          w_speedNext    = SPEED_ONE;
        end
        ST_RISE: begin
          w_tickCntNext  = w_tickAdvance;
          w_moveTickNext = w_tickWrap;
          if (r_flyTimer == '0) begin
            w_stateNext = ST_FALL;
            w_speedNext = SPEED_ONE;
          end else begin
            w_flyTimerNext = r_flyTimer - TIMER_ONE;
            if (w_tickWrap && (r_speed > SPEED_ONE)) begin
              w_speedNext = r_speed - SPEED_ONE;
            end
          end
        end
        ST_FALL: begin
          w_tickCntNext  = w_tickAdvance;
          w_moveTickNext = w_tickWrap;
          if (w_tickWrap && (r_speed < FALL_MAX)) begin
            w_speedNext = r_speed + SPEED_ONE;
          end
        end
        default: begin
          w_stateNext    = ST_IDLE;
          w_flyTimerNext = '0;
          w_tickCntNext  = '0;
          w_speedNext    = '0;
        end
      endcase
    end
  end

  assign bus.up         = r_up;
  assign bus.down       = r_down;
  assign bus.speed      = r_speed;
  assign bus.move_tick  = r_moveTick;
  assign bus.flap_pulse = r_flapPulse;

endmodule
